// File: rtl/mem_host_sequencer.sv
// Host-side bus sequencer for the memory controller: writes operands A, B and the
// opcode, pulses op_start, reads back the result word and returns it on a strobe.
module mem_host_sequencer #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [1:0]  ADDR_RES   = 2'd0,
  parameter logic [1:0]  ADDR_A     = 2'd1,
  parameter logic [1:0]  ADDR_B     = 2'd2,
  parameter logic [1:0]  ADDR_OP    = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [3:0] i_req_a,
  input  logic [3:0] i_req_b,
  input  logic [3:0] i_req_op,
  output logic       o_resp_valid,
  output logic [3:0] o_resp_data,
  output logic       o_busy,
  output logic       o_cs,
  output logic       o_wr_enb,
  output logic       o_rd_enb,
  output logic [1:0] o_addr,
  output logic [3:0] o_wr_data,
  output logic       o_op_start,
  input  logic [3:0] i_rd_data
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_A    = 4'd1;
  localparam logic [3:0] S_WR_B    = 4'd2;
  localparam logic [3:0] S_WR_OP   = 4'd3;
  localparam logic [3:0] S_START   = 4'd4;
  localparam logic [3:0] S_RD      = 4'd5;
  localparam logic [3:0] S_RD_WAIT = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_GAP     = 4'd8;

  localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);
  localparam logic [1:0] RDL_LOAD = 2'(RD_LATENCY - 1);

  logic [3:0] r_state;
  logic [3:0] r_ret;
  logic [2:0] r_gap_cnt;
  logic [1:0] r_rdl_cnt;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_op;

  logic       r_cs, r_wr_enb, r_rd_enb, r_op_start;
  logic       r_resp_valid, r_busy, r_req_ready;
  logic [1:0] r_addr;
  logic [3:0] r_wr_data;
  logic [3:0] r_resp_data;

  logic [3:0] w_state_next;
  logic [3:0] w_ret_next;
  logic       w_accept;
  logic       w_capture;

  assign w_accept  = (r_state == S_IDLE) && i_req_valid;
  assign w_capture = (r_state == S_RD_WAIT) && (r_rdl_cnt == 2'd0);

  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret;
    case (r_state)
      S_IDLE:    if (i_req_valid) w_state_next = S_WR_A;
      S_WR_A:    begin w_state_next = S_GAP; w_ret_next = S_WR_B;  end
      S_WR_B:    begin w_state_next = S_GAP; w_ret_next = S_WR_OP; end
      S_WR_OP:   begin w_state_next = S_GAP; w_ret_next = S_START; end
      S_START:   begin w_state_next = S_GAP; w_ret_next = S_RD;    end
      S_RD:      w_state_next = S_RD_WAIT;
      S_RD_WAIT: if (r_rdl_cnt == 2'd0) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      S_GAP:     if (r_gap_cnt == 3'd0) w_state_next = r_ret;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they appear registered
  // in the same cycle the state itself is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ret        <= S_IDLE;
      r_gap_cnt    <= 3'd0;
      r_rdl_cnt    <= 2'd0;
      r_a          <= 4'd0;
      r_b          <= 4'd0;
      r_op         <= 4'd0;
      r_cs         <= 1'b0;
      r_wr_enb     <= 1'b0;
      r_rd_enb     <= 1'b0;
      r_op_start   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_req_ready  <= 1'b1;
      r_addr       <= 2'd0;
      r_wr_data    <= 4'd0;
      r_resp_data  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_ret   <= w_ret_next;

      if (w_accept) begin
        r_a  <= i_req_a;
        r_b  <= i_req_b;
        r_op <= i_req_op;
      end

      if (w_state_next == S_GAP && r_state != S_GAP) r_gap_cnt <= GAP_LOAD;
      else if (r_state == S_GAP)                     r_gap_cnt <= r_gap_cnt - 3'd1;

      if (r_state == S_RD)           r_rdl_cnt <= RDL_LOAD;
      else if (r_state == S_RD_WAIT) r_rdl_cnt <= r_rdl_cnt - 2'd1;

      if (w_capture) r_resp_data <= i_rd_data;

      r_cs         <= (w_state_next == S_WR_A) || (w_state_next == S_WR_B) ||
                      (w_state_next == S_WR_OP) || (w_state_next == S_RD);
      r_wr_enb     <= (w_state_next == S_WR_A) || (w_state_next == S_WR_B) ||
                      (w_state_next == S_WR_OP);
      r_rd_enb     <= (w_state_next == S_RD);
      r_op_start   <= (w_state_next == S_START);
      r_resp_valid <= (w_state_next == S_DONE);
      r_busy       <= (w_state_next != S_IDLE);
      r_req_ready  <= (w_state_next == S_IDLE);

      // addr/wr_data only change on a strobe; they hold through gaps and op_start.
      case (w_state_next)
        S_WR_A:  begin r_addr <= ADDR_A;  r_wr_data <= w_accept ? i_req_a : r_a; end
        S_WR_B:  begin r_addr <= ADDR_B;  r_wr_data <= r_b;  end
        S_WR_OP: begin r_addr <= ADDR_OP; r_wr_data <= r_op; end
        S_RD:    r_addr <= ADDR_RES;
        default: ;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_busy       = r_busy;
  assign o_cs         = r_cs;
  assign o_wr_enb     = r_wr_enb;
  assign o_rd_enb     = r_rd_enb;
  assign o_addr       = r_addr;
  assign o_wr_data    = r_wr_data;
  assign o_op_start   = r_op_start;

endmodule
